// File: rtl/aes_encrypt_core_if.sv
// aes_encrypt_core_if: key-load, plaintext-in and ciphertext-out handshake bundle for the AES core
interface aes_encrypt_core_if #(parameter int KEY_BITS = 128);
    logic                set_key;
    logic [KEY_BITS-1:0] key;
    logic                key_loaded;
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        in_data;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        out_data;
    logic                halt;
    logic                busy;

    modport master (
        output set_key, key, in_valid, in_data, out_ready, halt,
        input  key_loaded, in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  set_key, key, in_valid, in_data, out_ready, halt,
        output key_loaded, in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128/256 encryptor, one round per clock, round keys expanded on the fly
module aes_encrypt_core #(
    parameter int KEY_BITS = 128
) (
    input logic clk,
    input logic rst,
    aes_encrypt_core_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [3:0] NR    = (KEY_BITS == 256) ? 4'd14 : 4'd10;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq = a;
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] base, input logic [31:0] src,
                                             input logic full, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = full ? subw({src[23:0], src[31:24]}) ^ {rc, 24'h0} : subw(src);
        w0 = base[127:96] ^ t;
        w1 = base[95:64] ^ w0;
        w2 = base[63:32] ^ w1;
        w3 = base[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic mix);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            o[127-32*c -: 8]  = mix ? xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3 : a0;
            o[119-32*c -: 8]  = mix ? a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3 : a1;
            o[111-32*c -: 8]  = mix ? a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3 : a2;
            o[103-32*c -: 8]  = mix ? xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3) : a3;
        end
        return o;
    endfunction

    logic [1:0]          st;
    logic [3:0]          rnd;
    logic [KEY_BITS-1:0] key_reg;
    logic [KEY_BITS-1:0] rk;
    logic [7:0]          rcon;
    logic                key_loaded;
    logic                valid_q;
    logic [127:0]        blk;
    logic                rdy;
    logic                full;
    logic [127:0]        nk_acc, nk_rnd, rnd_out;
    logic [KEY_BITS-1:0] rk_acc, rk_rnd;

    assign rdy     = (st == IDLE) && key_loaded && !bus.set_key && !bus.halt;
    assign full    = (KEY_BITS == 128) || !rnd[0];
    assign nk_acc  = next_rk(key_reg[KEY_BITS-1 -: 128], key_reg[31:0], 1'b1, 8'h01);
    assign nk_rnd  = next_rk(rk[KEY_BITS-1 -: 128], rk[31:0], full, rcon);
    assign rnd_out = aes_round(blk, rnd != NR) ^ rk[KEY_BITS-1 -: 128];

    // rk holds the current round key in its upper 128 bits; AES-256 keeps the following key below it
    generate
        if (KEY_BITS == 128) begin : g_128
            assign rk_acc = nk_acc;
            assign rk_rnd = nk_rnd;
        end else if (KEY_BITS == 256) begin : g_256
            assign rk_acc = {key_reg[127:0], nk_acc};
            assign rk_rnd = {rk[127:0], nk_rnd};
        end else begin : g_bad
            $error("aes_encrypt_core: KEY_BITS must be 128 or 256");
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            rnd        <= '0;
            key_reg    <= '0;
            rk         <= '0;
            rcon       <= '0;
            key_loaded <= 1'b0;
            valid_q    <= 1'b0;
            blk        <= '0;
        end else if (bus.halt) begin
            st      <= IDLE;
            rnd     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (bus.set_key && st == IDLE) begin
                key_reg    <= bus.key;
                key_loaded <= 1'b1;
            end
            if (rdy && bus.in_valid) begin
                blk  <= bus.in_data ^ key_reg[KEY_BITS-1 -: 128];
                rk   <= rk_acc;
                rcon <= 8'h02;
                rnd  <= 4'd1;
                st   <= ROUND;
            end
            if (st == ROUND) begin
                blk  <= rnd_out;
                rk   <= rk_rnd;
                rcon <= full ? xt(rcon) : rcon;
                rnd  <= rnd + 4'd1;
                if (rnd == NR) begin
                    st      <= DONE;
                    valid_q <= 1'b1;
                end
            end
            if (st == DONE && bus.out_ready) begin
                st      <= IDLE;
                rnd     <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.key_loaded = key_loaded;
    assign bus.in_ready   = rdy;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = blk;
    assign bus.busy       = st != IDLE;
endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: checks AES-128 and AES-256 builds against FIPS-197 vectors and a table-driven AES model
module tb_aes_encrypt_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_encrypt_core_if #(.KEY_BITS(128)) b1 ();
    aes_encrypt_core_if #(.KEY_BITS(256)) b2 ();
    aes_encrypt_core #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .bus(b1));
    aes_encrypt_core #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .bus(b2));

    logic [1:0]   sk, iv, ordy, hl;
    logic [255:0] key;
    logic [127:0] din;
    logic [1:0]   ov, ir, kl, bz;
    logic [127:0] dout [2];

    assign b1.set_key = sk[0];   assign b2.set_key = sk[1];
    assign b1.key = key[255:128]; assign b2.key = key;
    assign b1.in_valid = iv[0];  assign b2.in_valid = iv[1];
    assign b1.in_data = din;     assign b2.in_data = din;
    assign b1.out_ready = ordy[0]; assign b2.out_ready = ordy[1];
    assign b1.halt = hl[0];      assign b2.halt = hl[1];
    assign ov = {b2.out_valid, b1.out_valid};
    assign ir = {b2.in_ready, b1.in_ready};
    assign kl = {b2.key_loaded, b1.key_loaded};
    assign bz = {b2.busy, b1.busy};
    assign dout[0] = b1.out_data;
    assign dout[1] = b2.out_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    typedef struct {
        int           s;
        logic [255:0] k;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t tbl [3];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gx(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Textbook AES: full key schedule up front, then rounds over a byte array
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  st [16];
        logic [7:0]  sr [16];
        logic [7:0]  rc = 8'h01;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] o;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gx(rc);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) sr[i] = sb[st[4*((i/4 + i%4) % 4) + i%4]];
            for (int c = 0; c < 4; c++) begin
                a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
                if (r < nr) begin
                    st[4*c]   = gx(a0) ^ gx(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gx(a1) ^ gx(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gx(a2) ^ gx(a3) ^ a3;
                    st[4*c+3] = gx(a0) ^ a0 ^ a1 ^ a2 ^ gx(a3);
                end else begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    task automatic build_sbox();
        logic [7:0] p = 8'h01;
        logic [7:0] q = 8'h01;
        logic [7:0] x;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            q = q[7] ? q ^ 8'h09 : q;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int s, input logic [255:0] k);
        key = k;
        sk[s] = 1'b1;
        tick();
        sk[s] = 1'b0;
    endtask

    task automatic submit(input int s, input logic [127:0] pt);
        int n = 0;
        while (!ir[s] && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 128'(ir[s]), 128'd1);
        din = pt;
        iv[s] = 1'b1;
        tick();
        iv[s] = 1'b0;
    endtask

    task automatic collect(input int s, input bit ack, output logic [127:0] ct, output int lat);
        lat = 0;
        while (!ov[s] && lat < 40) begin
            tick();
            lat++;
        end
        ct = dout[s];
        if (ack) begin
            ordy[s] = 1'b1;
            tick();
            ordy[s] = 1'b0;
        end
    endtask

    task automatic run_block(input int s, input logic [255:0] k, input logic [127:0] pt,
                             input logic [127:0] exp, input string name);
        logic [127:0] ct;
        int lat;
        load_key(s, k);
        submit(s, pt);
        collect(s, 1'b1, ct, lat);
        chk(name, ct, exp);
        chk({name, "_latency"}, 128'(lat), (s != 0) ? 128'd14 : 128'd10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, snap, pt;
        logic [255:0] k;
        int lat;
        bit bad;
        build_sbox();
        tbl[0] = '{0, {C1_KEY, 128'h0}, C1_PT, C1_CT};
        tbl[1] = '{0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        tbl[2] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   C1_PT, 128'h8ea2b7ca516745bfeafc49904b496089};
        sk = '0; iv = 2'b11; ordy = '0; hl = '0; key = '0; din = C1_PT;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_outputs_128", {ov[0], ir[0], kl[0], bz[0], dout[0][123:0]}, 128'h0);
        chk("reset_outputs_256", {ov[1], ir[1], kl[1], bz[1], dout[1][123:0]}, 128'h0);
        chk("reset_data_top", {dout[0][127:124], dout[1][127:124]}, 128'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("no_key_in_ready", 128'(ir), 128'h0);
        chk("no_key_busy", 128'(bz), 128'h0);
        iv = '0;

        for (int i = 0; i < 3; i++) run_block(tbl[i].s, tbl[i].k, tbl[i].pt, tbl[i].ct, $sformatf("vector%0d", i));

        // back-pressure: result must hold and nothing new may enter
        load_key(0, {C1_KEY, 128'h0});
        submit(0, C1_PT);
        collect(0, 1'b0, ct, lat);
        chk("bp_result", ct, C1_CT);
        snap = ct;
        bad = 1'b0;
        din = 128'hdeadbeef;
        iv[0] = 1'b1;
        repeat (20) begin
            tick();
            bad = bad | (dout[0] !== snap) | !ov[0] | ir[0];
        end
        chk("bp_hold", 128'(bad), 128'h0);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("bp_release_valid", 128'(ov[0]), 128'h0);
        pt = {$urandom, $urandom, $urandom, $urandom};
        submit(0, pt);
        collect(0, 1'b1, ct, lat);
        chk("bp_next_block", ct, aes_ref({C1_KEY, 128'h0}, 4, pt));

        // halt while the round counter reads 5
        submit(0, C1_PT);
        repeat (4) tick();
        hl[0] = 1'b1;
        #1;
        chk("halt_in_ready", 128'(ir[0]), 128'h0);
        tick();
        chk("halt_idle", {126'h0, bz[0], ov[0]}, 128'h0);
        hl[0] = 1'b0;
        #1;
        chk("halt_key_kept", {126'h0, kl[0], ir[0]}, 128'h3);
        bad = 1'b0;
        repeat (16) begin
            tick();
            bad = bad | ov[0];
        end
        chk("halt_no_valid", 128'(bad), 128'h0);
        submit(0, C1_PT);
        collect(0, 1'b1, ct, lat);
        chk("halt_resubmit", ct, C1_CT);
        chk("halt_resubmit_latency", 128'(lat), 128'd10);

        // a key offered mid-block is ignored entirely
        submit(0, C1_PT);
        tick();
        key = '0;
        sk[0] = 1'b1;
        tick();
        sk[0] = 1'b0;
        collect(0, 1'b1, ct, lat);
        chk("midkey_current", ct, C1_CT);
        submit(0, C1_PT);
        collect(0, 1'b1, ct, lat);
        chk("midkey_next", ct, C1_CT);
        run_block(0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "idle_zero_key");

        for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < 2; s++) begin
                k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                pt = {$urandom, $urandom, $urandom, $urandom};
                run_block(s, k, pt, aes_ref(k, (s != 0) ? 8 : 4, pt), $sformatf("rand%0d_%0d", s, i));
            end
        end

        // asynchronous reset in the middle of a block
        submit(1, C1_PT);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {ov[1], ir[1], kl[1], bz[1], dout[1][123:0]}, 128'h0);
        chk("async_rst_data_top", 128'(dout[1][127:124]), 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_key_loaded", {126'h0, kl[1], ir[1]}, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
